// File: rtl/leaf_uplink_arbiter_pkg.sv
// Shared NoC flit definitions and the arbiter's burst FSM state type.
package leaf_uplink_arbiter_pkg;

  localparam int unsigned NOC_DATA_W   = 16;
  localparam int unsigned NOC_HEADER_W = 6;
  localparam int unsigned NOC_GROUP_W  = 4;
  localparam int unsigned NOC_LEAF_W   = 2;
  localparam int unsigned NOC_N_LEAF   = 4;

  typedef logic [NOC_DATA_W-1:0] flit_t;

  typedef enum logic {
    StIdle,
    StBurst
  } burst_state_e;

  // Header occupies the top bits: {group, leaf}.
  function automatic logic [NOC_HEADER_W-1:0] flit_header(input flit_t f);
    return f[NOC_DATA_W-1 -: NOC_HEADER_W];
  endfunction

  function automatic logic [NOC_GROUP_W-1:0] flit_group(input flit_t f);
    return f[NOC_DATA_W-1 -: NOC_GROUP_W];
  endfunction

  function automatic logic [NOC_LEAF_W-1:0] flit_leaf(input flit_t f);
    return f[NOC_DATA_W-NOC_GROUP_W-1 -: NOC_LEAF_W];
  endfunction

endpackage

// File: rtl/leaf_uplink_arbiter_if.sv
// Requester-side valid/ready bundle plus router-side registered output of the uplink arbiter.
interface leaf_uplink_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [IDX_W-1:0]        grant_idx;

  // Arbiter side.
  modport slave (
    input  req_data, req_valid, out_ready,
    output req_ready, out_data, out_valid, grant_idx
  );

  // Environment side: NIs and router.
  modport master (
    output req_data, req_valid, out_ready,
    input  req_ready, out_data, out_valid, grant_idx
  );

endinterface

// File: rtl/leaf_uplink_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo N.
module leaf_uplink_arbiter_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);
  localparam int unsigned IDX_W = $clog2(N);

  always_comb begin
    logic        w_found;
    int unsigned w_pos;
    w_found = 1'b0;
    w_pos   = 0;
    o_grant = '0;
    o_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = (32'(i_ptr) + k) % N;
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IDX_W'(w_pos);
      end
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/leaf_uplink_arbiter.sv
// N_REQ-to-1 round-robin uplink arbiter with a 1-entry output register.
// Optional `ARB_BURST_EN: keep the grant on one requester for up to MAX_BURST flits.
module leaf_uplink_arbiter
  import leaf_uplink_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = NOC_DATA_W,
  parameter int unsigned MAX_BURST = 4
) (
  input logic                 clk,
  input logic                 reset,
  leaf_uplink_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic [IDX_W-1:0]  r_grant_idx;
  logic [IDX_W-1:0]  r_rr_ptr;

  logic              w_load_en;
  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_idx;
  logic              w_any;
  logic              w_accept;
  logic [IDX_W-1:0]  w_ptr_next;
  logic [DATA_W-1:0] w_sel_data;

  assign w_load_en  = !r_out_valid || bus.out_ready;
  assign w_accept   = w_load_en && w_any && !reset;
  assign w_ptr_next = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_sel_data = bus.req_data[32'(w_idx)*DATA_W +: DATA_W];

  leaf_uplink_arbiter_picker #(
    .N (N_REQ)
  ) u_picker (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

`ifdef ARB_BURST_EN
  localparam int unsigned CNT_W = 4;

  burst_state_e     r_state, w_state_d;
  logic [IDX_W-1:0] r_lock, w_lock_d;
  logic [CNT_W-1:0] r_burst_cnt, w_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_lock      <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_lock      <= w_lock_d;
      r_burst_cnt <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_lock_d  = r_lock;
    w_cnt_d   = r_burst_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept && (MAX_BURST > 1)) begin
          w_state_d = StBurst;
          w_lock_d  = w_idx;
          w_cnt_d   = CNT_W'(1);
        end
      end
      StBurst: begin
        // A load slot with the locked requester idle ends the burst without a grant.
        if (w_load_en && !bus.req_valid[r_lock]) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (w_accept) begin
          w_cnt_d = r_burst_cnt + 1'b1;
          if (w_cnt_d == CNT_W'(MAX_BURST)) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_elig = bus.req_valid;
    if (r_state == StBurst) w_elig = bus.req_valid & (N_REQ'(1) << r_lock);
  end
`else
  assign w_elig = bus.req_valid;
`endif

  // rr_ptr always advances past the winner; in burst mode this equals lock+1 on exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_out_data  <= w_sel_data;
      r_out_valid <= 1'b1;
      r_grant_idx <= w_idx;
      r_rr_ptr    <= w_ptr_next;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_accept ? w_grant : '0;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.grant_idx = r_grant_idx;

endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// Directed self-checking bench for leaf_uplink_arbiter (N_REQ=4, DATA_W=16).
module tb_leaf_uplink_arbiter;
  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  leaf_uplink_arbiter_if #(.N_REQ(4), .DATA_W(16)) bus ();

  leaf_uplink_arbiter #(
    .N_REQ     (4),
    .DATA_W    (16),
    .MAX_BURST (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [15:0] v);
    bus.req_data[i*16 +: 16] = v;
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    reset         = 1'b1;
    bus.req_data  = '0;
    bus.req_valid = 4'hf;
    bus.out_ready = 1'b1;
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_grant_idx", 32'(bus.grant_idx), 32'h0);

    // All four valid from reset: grant order 0,1,2,3,0, one flit per cycle.
    for (int i = 0; i < 4; i++) set_data(i, 16'hA000 + 16'(i));
    step();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_ready_%0d", k), 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
      step();
      check($sformatf("rr_data_%0d", k), 32'(bus.out_data), 32'h0000A000 + 32'(k % 4));
      check($sformatf("rr_idx_%0d", k), 32'(bus.grant_idx), 32'(k % 4));
      check($sformatf("rr_valid_%0d", k), 32'(bus.out_valid), 32'h1);
    end

    // Stall five cycles: nothing accepted, out_data held.
    bus.out_ready = 1'b0;
    #1;
    check("stall_ready_0", 32'(bus.req_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("stall_data_%0d", k), 32'(bus.out_data), 32'h0000A000);
      check($sformatf("stall_ready_%0d", k), 32'(bus.req_ready), 32'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_ready", 32'(bus.req_ready), 32'h2);
    step();
    check("release_data", 32'(bus.out_data), 32'h0000A001);
    check("release_idx",  32'(bus.grant_idx), 32'h1);

    // Reset with a flit held: flit discarded, ready low, pointer back to 0.
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'h0);
    check("midrst_out_data",  32'(bus.out_data),  32'h0);
    step();
    reset = 1'b0;
    #1;
    check("midrst_ptr0", 32'(bus.req_ready), 32'h1);

    // Single requester 2 sends two flits.
    bus.req_valid = 4'b0100;
    set_data(2, 16'h5003);
    #1;
    check("single_ready_0", 32'(bus.req_ready), 32'h4);
    step();
    check("single_data_0", 32'(bus.out_data), 32'h5003);
    check("single_idx_0",  32'(bus.grant_idx), 32'h2);
    set_data(2, 16'h5004);
    #1;
    check("single_ready_1", 32'(bus.req_ready), 32'h4);
    step();
    check("single_data_1", 32'(bus.out_data), 32'h5004);
    check("single_idx_1",  32'(bus.grant_idx), 32'h2);
    bus.req_valid = 4'b0000;
    step();
    check("drain_valid", 32'(bus.out_valid), 32'h0);
    check("drain_hold",  32'(bus.out_data), 32'h5004);

    // rr_ptr is 3; requesters 0 and 1 valid: wrap to 0, then pointer at 1.
    bus.req_valid = 4'b0011;
    set_data(0, 16'h1111);
    set_data(1, 16'h2222);
    #1;
    check("wrap_ready", 32'(bus.req_ready), 32'h1);
    step();
    check("wrap_data", 32'(bus.out_data), 32'h1111);
    check("wrap_idx",  32'(bus.grant_idx), 32'h0);
    check("wrap_next_ready", 32'(bus.req_ready), 32'h2);
    step();
    check("wrap_next_data", 32'(bus.out_data), 32'h2222);

`ifdef ARB_BURST_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("burst_idx_%0d", k), 32'(bus.grant_idx), (k < 4) ? 32'h0 : 32'h1);
      check($sformatf("burst_data_%0d", k), 32'(bus.out_data), (k < 4) ? 32'h1111 : 32'h2222);
    end
    // Pointer now 2: requester 0 wins, drops after two flits, grant moves to 1.
    step();
    check("bdrop_idx_0", 32'(bus.grant_idx), 32'h0);
    step();
    check("bdrop_idx_1", 32'(bus.grant_idx), 32'h0);
    bus.req_valid = 4'b0010;
    #1;
    check("bdrop_gap", 32'(bus.req_ready), 32'h0);
    step();
    check("bdrop_switch", 32'(bus.req_ready), 32'h2);
    step();
    check("bdrop_idx_2", 32'(bus.grant_idx), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
